// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester (A) and a data requester (B). One transaction is in flight at
// a time; the winner is steered onto the port through Mux_Sel and gets a
// one-cycle Done pulse (with Err on timeout) when its transaction ends.
module mem_port_arbiter #(
  parameter int PRIO_MODE    = 0,   // 0: round-robin, 1: B first with A starvation guard
  parameter int STARVE_LIMIT = 4,   // B wins over a waiting A before A is forced through
  parameter int RSP_TIMEOUT  = 255  // WAIT_RSP cycles before the transaction is aborted
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Req_A,
  input  logic Req_B,
  output logic Gnt_A,
  output logic Gnt_B,
  output logic Done_A,
  output logic Done_B,
  output logic Err,
  output logic Mux_Sel,
  output logic Mem_Req_Valid,
  input  logic Mem_Req_Ready,
  input  logic Mem_Rsp_Valid,
  output logic Busy
);

  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(RSP_TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t          state_q;
  logic            mux_sel_q;
  logic            last_gnt_q;  // 0 = A, 1 = B
  logic [SW-1:0]   starve_q;
  logic [TW-1:0]   tmo_q;
  logic            gnt_a_q, gnt_b_q, valid_q, busy_q;

  logic            win_b;
  logic            tmo_hit;
  logic            fin;

  // Winner selection for the IDLE->ISSUE decision (1 = B wins)
  always_comb begin
    win_b = Req_B;
    if (Req_A && Req_B) begin
      if (PRIO_MODE == 0) win_b = ~last_gnt_q;          // alternate against last owner
      else                win_b = (starve_q != STARVE_MX); // A forced once B has starved it
    end
  end

  // Transaction completion in WAIT_RSP: response wins over a same-cycle timeout
  always_comb begin
    tmo_hit = (tmo_q == TMO_LAST);
    fin     = (state_q == WAIT_RSP) && (Mem_Rsp_Valid || tmo_hit);
  end

  // Sequencer: IDLE -> ISSUE -> WAIT_RSP -> IDLE with registered grant/valid/busy
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      mux_sel_q  <= 1'b0;
      last_gnt_q <= 1'b1;  // A wins the first round-robin tie
      starve_q   <= '0;
      tmo_q      <= '0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req_A || Req_B) begin
            state_q   <= ISSUE;
            mux_sel_q <= win_b;
            gnt_a_q   <= ~win_b;
            gnt_b_q   <= win_b;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            if (PRIO_MODE != 0) begin
              if (!win_b)
                starve_q <= '0;
              else if (Req_A && starve_q != STARVE_MX)
                starve_q <= starve_q + SW'(1);
            end
          end
        end
        ISSUE: begin
          if (Mem_Req_Ready) begin
            state_q <= WAIT_RSP;
            valid_q <= 1'b0;
            tmo_q   <= '0;
          end
        end
        WAIT_RSP: begin
          if (fin) begin
            state_q    <= IDLE;
            last_gnt_q <= mux_sel_q;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_a_q <= 1'b0;
          gnt_b_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Gnt_A         = gnt_a_q;
  assign Gnt_B         = gnt_b_q;
  assign Mux_Sel       = mux_sel_q;
  assign Mem_Req_Valid = valid_q;
  assign Busy          = busy_q;
  assign Done_A        = fin & ~mux_sel_q;
  assign Done_B        = fin &  mux_sel_q;
  assign Err           = fin & ~Mem_Rsp_Valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin and fixed-priority),
// a directed vector table, hand-written corner sequences and a random run
// checked every cycle against a transaction-phase reference model.
module tb_mem_port_arbiter;

  localparam int TMO   = 8;
  localparam int LIMIT = 2;

  logic       Clk = 1'b0;
  logic [1:0] rst, ra, rb, rdy, rsp;
  logic [1:0] ga, gb, da, db, er, ms, mv, bz;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_en   = 1'b0;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(4), .RSP_TIMEOUT(TMO)) dut0 (
    .Clk(Clk), .Rst(rst[0]), .Req_A(ra[0]), .Req_B(rb[0]),
    .Gnt_A(ga[0]), .Gnt_B(gb[0]), .Done_A(da[0]), .Done_B(db[0]), .Err(er[0]),
    .Mux_Sel(ms[0]), .Mem_Req_Valid(mv[0]), .Mem_Req_Ready(rdy[0]),
    .Mem_Rsp_Valid(rsp[0]), .Busy(bz[0]));

  mem_port_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(LIMIT), .RSP_TIMEOUT(TMO)) dut1 (
    .Clk(Clk), .Rst(rst[1]), .Req_A(ra[1]), .Req_B(rb[1]),
    .Gnt_A(ga[1]), .Gnt_B(gb[1]), .Done_A(da[1]), .Done_B(db[1]), .Err(er[1]),
    .Mux_Sel(ms[1]), .Mem_Req_Valid(mv[1]), .Mem_Req_Ready(rdy[1]),
    .Mem_Rsp_Valid(rsp[1]), .Busy(bz[1]));

  // Reference model: phase 0 idle, 1 request offered, 2 awaiting response.
  typedef struct {
    int ph;
    bit owner;   // 0 = A, 1 = B
    bit last;
    int starve;
    int waited;  // WAIT cycles already spent without response
  } mdl_t;

  mdl_t m[2];

  // output bits: {Gnt_A,Gnt_B,Done_A,Done_B,Err,Mux_Sel,Valid,Busy}
  function automatic logic [7:0] mdl_out(mdl_t s, logic r);
    bit fin;
    fin = (s.ph == 2) && (r || (s.waited + 1 == TMO));
    return {s.ph != 0 && !s.owner, s.ph != 0 && s.owner, fin && !s.owner,
            fin && s.owner, fin && !r, s.owner, s.ph == 1, s.ph != 0};
  endfunction

  function automatic mdl_t mdl_next(mdl_t s, int prio, logic r, logic a, logic b,
                                    logic rd, logic rs);
    mdl_t n;
    bit w;
    n = s;
    if (r) begin
      n.ph = 0; n.owner = 0; n.last = 1; n.starve = 0; n.waited = 0;
      return n;
    end
    case (s.ph)
      0: if (a || b) begin
        if (a && b) w = (prio == 0) ? !s.last : (s.starve < LIMIT);
        else        w = b;
        if (prio != 0) begin
          if (!w)     n.starve = 0;
          else if (a) n.starve = (s.starve + 1 > LIMIT) ? LIMIT : s.starve + 1;
        end
        n.owner = w;
        n.ph    = 1;
      end
      1: if (rd) begin n.ph = 2; n.waited = 0; end
      default: begin
        if (rs || (s.waited + 1 == TMO)) begin n.ph = 0; n.last = s.owner; end
        else n.waited = s.waited + 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [7:0] obs(int i);
    return {ga[i], gb[i], da[i], db[i], er[i], ms[i], mv[i], bz[i]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // model advances on the same edge as the DUTs
  always @(posedge Clk) begin
    m[0] <= mdl_next(m[0], 0, rst[0], ra[0], rb[0], rdy[0], rsp[0]);
    m[1] <= mdl_next(m[1], 1, rst[1], ra[1], rb[1], rdy[1], rsp[1]);
  end

  // continuous comparison of all outputs against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++)
        check($sformatf("cycle_dut%0d", i), 32'(obs(i)), 32'(mdl_out(m[i], rsp[i])));
    end
  end

  task automatic drive(logic r, logic a, logic b, logic rd, logic rs);
    rst = {2{r}}; ra = {2{a}}; rb = {2{b}}; rdy = {2{rd}}; rsp = {2{rs}};
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    @(posedge Clk); #1;
    rst = 2'b00;
  endtask

  typedef struct packed {
    logic rst, a, b, rd, rs;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [5:0] ord[2];
    int         n[2];
    int         wcnt[2], dcyc[2];
    logic [1:0] errv;
    int         vcnt, selchg, errs, dones;
    logic [7:0] e;
    logic [1:0] dropa, dropb;

    // A only, Ready=1, response two cycles after accept
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h83};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h81};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};

    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    chk_en = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].a, tbl[k].b, tbl[k].rd, tbl[k].rs);
      @(negedge Clk);
      for (int i = 0; i < 2; i++)
        check($sformatf("vec%0d_dut%0d", k, i), 32'(obs(i)), 32'(tbl[k].exp));
      @(posedge Clk); #1;
    end

    // both held: RR alternates A,B,...; priority gives B,B,A,...
    do_reset();
    drive(0, 1, 1, 1, 1);
    ord[0] = 'x; ord[1] = 'x; n[0] = 0; n[1] = 0;
    for (int c = 0; c < 40 && (n[0] < 6 || n[1] < 6); c++) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++)
        if (mv[i] && n[i] < 6) begin ord[i][5 - n[i]] = ms[i]; n[i]++; end
    end
    check("rr_order",   32'(ord[0]), 32'(6'b010101));
    check("prio_order", 32'(ord[1]), 32'(6'b110110));

    // B only, no response: timeout on the 8th WAIT cycle
    do_reset();
    drive(0, 0, 1, 1, 0);
    wcnt[0] = 0; wcnt[1] = 0; dcyc[0] = -1; dcyc[1] = -1; errv = 2'b00;
    for (int c = 0; c < 40 && (dcyc[0] < 0 || dcyc[1] < 0); c++) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        if (bz[i] && !mv[i] && dcyc[i] < 0) wcnt[i]++;
        if (db[i] && dcyc[i] < 0) begin dcyc[i] = wcnt[i]; errv[i] = er[i]; end
      end
    end
    @(posedge Clk); #1;
    rb = 2'b00;
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tmo_cycle_dut%0d", i), 32'(dcyc[i]), 32'(TMO));
      check($sformatf("tmo_err_dut%0d", i), 32'(errv[i]), 32'(1));
      check($sformatf("tmo_idle_dut%0d", i), 32'(bz[i]), 32'(0));
    end

    // Ready low for 5 ISSUE cycles; response already high (ignored until WAIT)
    do_reset();
    drive(0, 1, 0, 0, 1);
    vcnt = 0; selchg = 0; errs = 0; dones = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge Clk);
      if (mv[0]) begin vcnt++; if (ms[0] !== 1'b0) selchg++; end
      if (er[0]) errs++;
      if (da[0]) dones++;
      @(posedge Clk); #1;
      rdy = (vcnt >= 5) ? 2'b11 : 2'b00;
      if (dones > 0) ra = 2'b00;
    end
    check("stall_valid_cycles", 32'(vcnt), 32'(6));
    check("stall_sel_stable", 32'(selchg), 32'(0));
    check("stall_no_err", 32'(errs), 32'(0));
    check("stall_one_done", 32'(dones), 32'(1));

    // reset while B waits for its response
    do_reset();
    drive(0, 0, 1, 1, 0);
    repeat (3) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("pre_rst_sel", 32'({ms[1], ms[0], bz}), 32'(4'b1111));
    @(posedge Clk); #1;
    rst = 2'b11;
    @(negedge Clk);
    check("rst_no_done", 32'({da, db, er}), 32'(0));
    @(posedge Clk); #1;
    drive(0, 0, 0, 0, 0);
    @(negedge Clk);
    check("rst_outputs", 32'({obs(1), obs(0)}), 32'(0));
    @(posedge Clk); #1;

    // random traffic; requests held until the model says Done
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        e = mdl_out(m[i], rsp[i]);
        dropa[i] = e[5];
        dropb[i] = e[4];
      end
      @(posedge Clk); #1;
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 149) == 0);
        ra[i]  = dropa[i] ? 1'b0 : (ra[i] || ($urandom_range(0, 2) == 0));
        rb[i]  = dropb[i] ? 1'b0 : (rb[i] || ($urandom_range(0, 2) == 0));
        rdy[i] = ($urandom_range(0, 2) != 0);
        rsp[i] = ($urandom_range(0, 4) == 0);
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
